// File: rtl/frame_word_aligner.sv
// Frame word aligner: steps the deserializer slip address until the sync
// pattern is found, confirms lock over consecutive good frames, then forwards frames.
`timescale 1ns/1ps
module frame_word_aligner #(
    parameter int          FRAMEWIDTH    = 40,
    parameter int          ADDRWIDTH     = 6,
    parameter logic [15:0] SYNC_PATTERN  = 16'h3C5C,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          LOCK_COUNT    = 8,
    parameter int          UNLOCK_COUNT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAMEWIDTH-1:0] din,
    output logic [ADDRWIDTH-1:0]  wordAddr,
    output logic                  aligned,
    output logic [FRAMEWIDTH-1:0] dout,
    output logic                  doutValid,
    output logic [15:0]           slipCount,
    output logic [19:0]           frameErrorCount,
    output logic [7:0]            relockCount
);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    localparam int GW = $clog2(LOCK_COUNT + 2);
    localparam int BW = $clog2(UNLOCK_COUNT + 2);
    localparam logic [SW-1:0]        SETTLE_N  = SW'(SETTLE_CYCLES);
    localparam logic [GW-1:0]        LOCK_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0]        BAD_LAST  = BW'(UNLOCK_COUNT - 1);
    localparam logic [ADDRWIDTH-1:0] ADDR_LAST = ADDRWIDTH'(FRAMEWIDTH - 1);

    typedef enum logic [1:0] {SETTLE, SEARCH, CONFIRM, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [ADDRWIDTH-1:0]  addr_q, addr_d;
    logic [GW-1:0]         good_run_q, good_run_d;
    logic [BW-1:0]         bad_run_q, bad_run_d;
    logic [15:0]           slip_q, slip_d;
    logic [19:0]           ferr_q, ferr_d;
    logic [7:0]            relock_q, relock_d;
    logic [FRAMEWIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  aligned_q, aligned_d;
    logic                  good;
    logic                  slip_req;
    logic [1:0]            frame_type;

    // Header (00) and filler (10) are the only legal frame types behind the sync word.
    assign frame_type = din[FRAMEWIDTH-17 -: 2];
    assign good = (din[FRAMEWIDTH-1 -: 16] == SYNC_PATTERN) &&
                  ((frame_type == 2'b00) || (frame_type == 2'b10));

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        addr_d     = addr_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        slip_d     = slip_q;
        ferr_d     = ferr_q;
        relock_d   = relock_q;
        slip_req   = 1'b0;
        case (state_q)
            SETTLE: begin
                if (settle_q > SW'(1)) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    settle_d = '0;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                if (good) begin
                    good_run_d = GW'(1);
                    bad_run_d  = '0;
                    state_d    = (LOCK_COUNT <= 1) ? LOCKED : CONFIRM;
                end else begin
                    slip_req = 1'b1;
                end
            end
            CONFIRM: begin
                if (good) begin
                    good_run_d = good_run_q + 1'b1;
                    if (good_run_q >= LOCK_LAST) begin
                        state_d   = LOCKED;
                        bad_run_d = '0;
                    end
                end else begin
                    slip_req   = 1'b1;
                    good_run_d = '0;
                end
            end
            LOCKED: begin
                if (good) begin
                    bad_run_d = '0;
                end else begin
                    if (ferr_q != '1) ferr_d = ferr_q + 1'b1;
                    bad_run_d = bad_run_q + 1'b1;
                    // Drop back to SEARCH on the same address so it is retested first.
                    if (bad_run_q >= BAD_LAST) begin
                        state_d    = SEARCH;
                        bad_run_d  = '0;
                        good_run_d = '0;
                        if (relock_q != '1) relock_d = relock_q + 1'b1;
                    end
                end
            end
            default: state_d = SETTLE;
        endcase
        if (slip_req) begin
            addr_d   = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            settle_d = SETTLE_N;
            state_d  = SETTLE;
            if (slip_q != '1) slip_d = slip_q + 1'b1;
        end
    end

    // Output register keys off the next state so dout is zero whenever aligned is low.
    assign aligned_d    = (state_d == LOCKED);
    assign dout_d       = aligned_d ? din : '0;
    assign dout_valid_d = aligned_d && good;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SETTLE;
            settle_q     <= SETTLE_N;
            addr_q       <= '0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            slip_q       <= '0;
            ferr_q       <= '0;
            relock_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            aligned_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            addr_q       <= addr_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            slip_q       <= slip_d;
            ferr_q       <= ferr_d;
            relock_q     <= relock_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            aligned_q    <= aligned_d;
        end
    end

    assign wordAddr        = addr_q;
    assign aligned         = aligned_q;
    assign dout            = dout_q;
    assign doutValid       = dout_valid_q;
    assign slipCount       = slip_q;
    assign frameErrorCount = ferr_q;
    assign relockCount     = relock_q;
endmodule

// File: doc/frame_word_aligner.md
Name: frame_word_aligner

Overview:
- Receiver-side stage placed directly after the 40-bit deserializer in the ETROC2 readout bench.
- Finds the 40-bit frame boundary in the serial link by stepping the deserializer word-slip address until the sync pattern appears.
- Declares lock after consecutive good frames, then forwards aligned frames to the descrambler and record checker.
- Tracks loss of lock and keeps error and slip statistics.

Parameters:
- FRAMEWIDTH, 40: deserialized word width in bits.
- ADDRWIDTH, 6: width of the slip address; legal values are 0..FRAMEWIDTH-1.
- SYNC_PATTERN, 16'h3C5C: required value of din[39:24].
- SETTLE_CYCLES, 4: idle cycles after every slip change before checking resumes (covers deserializer latency).
- LOCK_COUNT, 8: consecutive good frames needed to declare lock.
- UNLOCK_COUNT, 4: consecutive bad frames that drop lock.

Ports:
- clk, input, 1: word clock, one deserialized word per cycle.
- reset, input, 1: asynchronous active-low reset.
- din, input, FRAMEWIDTH: deserialized word.
- wordAddr, output, ADDRWIDTH: slip address sent to the deserializer delay input.
- aligned, output, 1: high while in LOCKED.
- dout, output, FRAMEWIDTH: registered aligned frame; all zeros when aligned=0.
- doutValid, output, 1: dout is a good frame and aligned=1.
- slipCount, output, 16: number of slip increments, saturating.
- frameErrorCount, output, 20: bad frames seen while LOCKED, saturating.
- relockCount, output, 8: number of LOCKED->SEARCH exits, saturating.

Behaviour:
- Good frame: din[39:24]==SYNC_PATTERN and din[23:22] is either 2'b00 (header) or 2'b10 (filler). Any other value is a bad frame.
- Reset (reset=0, async):
  - state=SETTLE, wordAddr=0, settle counter=SETTLE_CYCLES.
  - All counters 0; aligned=0, dout=0, doutValid=0.
- SETTLE:
  - Settle counter decrements each cycle; din is ignored.
  - At 0 the FSM moves to SEARCH on the next cycle.
- SEARCH:
  - Good frame -> CONFIRM, goodRun=1.
  - Bad frame -> wordAddr increments (FRAMEWIDTH-1 wraps to 0), slipCount+1, counter reloads, FSM -> SETTLE.
- CONFIRM:
  - Good frame -> goodRun+1. When goodRun reaches LOCK_COUNT, FSM -> LOCKED, so aligned rises on the cycle after the LOCK_COUNT-th consecutive good frame.
  - Bad frame -> same slip action as in SEARCH, goodRun=0.
- LOCKED:
  - aligned=1; dout<=din every cycle, so dout has 1-cycle latency.
  - doutValid<=good(din).
  - Bad frame -> frameErrorCount+1, badRun+1. Good frame -> badRun=0.
  - When badRun reaches UNLOCK_COUNT:
    - FSM -> SEARCH with wordAddr unchanged, so the current address is retested first.
    - aligned=0 and dout=0 from the next cycle; relockCount+1; goodRun=0.
- Frames in LOCKED are passed through even when bad (doutValid=0), so downstream can count errors.
- All statistics counters saturate at all-ones and do not wrap.
- wordAddr changes only on a slip. It is held through SETTLE, CONFIRM and LOCKED.
- Reset mid-lock drops aligned immediately (async) and restarts from address 0.
- At most one slip per SETTLE_CYCLES+1 cycles; a full sweep of 40 addresses is therefore bounded at 40*(SETTLE_CYCLES+1) cycles when no pattern is present.

Test Plan:
1. Link word-shifted by 13 bits, continuous filler frames:
   - wordAddr steps 0..13, then holds; slipCount=13.
   - aligned rises 8 good cycles after wordAddr=13 settles.
   - dout[39:24]=16'h3C5C with doutValid=1.
2. din held at 40'h0 for 250 cycles:
   - wordAddr wraps 39->0 after the 40th slip.
   - aligned stays 0; slipCount=48 at cycle 240 (40 slips at cycles 5, 10, ... 200, plus 8 more).
3. Locked link, inject 3 bad frames then 1 good:
   - aligned stays 1; frameErrorCount=3; doutValid low exactly for those 3 cycles, delayed 1 cycle.
4. Locked link, inject 4 consecutive bad frames:
   - aligned falls the cycle after the 4th; relockCount=1; wordAddr unchanged.
   - Restoring good frames relocks after 8 frames with no slip.
5. 7 good frames then 1 bad while in CONFIRM:
   - No lock; slip to wordAddr+1; slipCount increments by 1.
6. Assert reset low for 1 ns mid-LOCKED, asynchronous to clk:
   - aligned, dout, wordAddr and all counters read 0 immediately.
   - After release, first slip check occurs after 4 settle cycles.
